// File: rtl/fsm_stim_tx.sv
// Serial stimulus driver for single-bit x/y FSMs: shifts a pattern out MSB-first and captures the y response.
// Optional y=1 accumulator on ones_cnt is built only when FSM_STIM_ONES_CNT_EN is defined.
module fsm_stim_tx #(
    parameter int WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [WIDTH-1:0]               data_in,
    input  logic                           y,
    output logic                           x,
    output logic                           busy,
    output logic                           done,
    output logic [WIDTH-1:0]               resp,
    output logic [$clog2(WIDTH+1)-1:0]     ones_cnt
);

    localparam int CNT_W  = $clog2(WIDTH);
    localparam int ONES_W = $clog2(WIDTH+1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               x_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   resp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            resp_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    x_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                    if (start) begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        shift_q <= data_in;
                        cnt_q   <= CNT_W'(WIDTH-1);
                        x_q     <= data_in[WIDTH-1];
                        resp_q  <= '0;
                    end
                end
                SHIFT: begin
                    // y is the Mealy response to the x currently on the wire
                    resp_q <= {resp_q[WIDTH-2:0], y};
                    if (cnt_q != '0) begin
                        x_q     <= shift_q[WIDTH-2];
                        shift_q <= shift_q << 1;
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end else begin
                        x_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FSM_STIM_ONES_CNT_EN
    logic [ONES_W-1:0] ones_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ones_q <= '0;
        end else if (state_q == SHIFT) begin
            ones_q <= ones_q + ONES_W'(y);
        end else if (start) begin
            ones_q <= '0;
        end
    end

    assign ones_cnt = ones_q;
`else
    assign ones_cnt = '0;
`endif

    assign x    = x_q;
    assign busy = busy_q;
    assign done = done_q;
    assign resp = resp_q;

endmodule

// File: tb/tb_fsm_stim_tx.sv
// Randomised self-checking bench for fsm_stim_tx (WIDTH=8 main instance plus a WIDTH=2 instance).
module tb_fsm_stim_tx;

    localparam int W  = 8;
    localparam int OW = $clog2(W+1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  data_in;
    logic          y;
    logic          y_drv;
    logic          loop_en;
    logic          x, busy, done;
    logic [W-1:0]  resp;
    logic [OW-1:0] ones;

    logic          start2;
    logic [1:0]    data2;
    logic          x2, busy2, done2;
    logic [1:0]    resp2;
    logic [1:0]    ones2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign y = loop_en ? x : y_drv;

    fsm_stim_tx #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in), .y(y),
        .x(x), .busy(busy), .done(done), .resp(resp), .ones_cnt(ones)
    );

    fsm_stim_tx #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .data_in(data2), .y(~x2),
        .x(x2), .busy(busy2), .done(done2), .resp(resp2), .ones_cnt(ones2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_ones(input int n);
`ifdef FSM_STIM_ONES_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    // mode 0: y looped back from x, 1: y tied high, 3: random y per bit
    task automatic xfer(input logic [W-1:0] pat, input int mode, input bit preloaded,
                        input bit inject, input bit chain, input logic [W-1:0] next_pat,
                        output int done_cyc);
        logic [W-1:0] er;
        int n;
        int e;
        er = '0;
        n  = 0;
        if (!preloaded) begin
            @(negedge clk);
            start   = 1'b1;
            data_in = pat;
        end
        loop_en = (mode == 0);
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = W'($urandom);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("x_bit", x, pat[W-1-i]);
            chk("busy_shift", busy, 1);
            chk("done_low_shift", done, 0);
            if (mode == 0) begin
                e = int'(pat[W-1-i]);
            end else if (mode == 1) begin
                y_drv = 1'b1;
                e = 1;
            end else begin
                e = int'($urandom_range(0, 1));
                y_drv = e[0];
            end
            er[W-1-i] = e[0];
            n += e;
            if (inject && i == 2) begin
                start   = 1'b1;
                data_in = ~pat;
            end else if (inject && i == 3) begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("x_done", x, 0);
        chk("resp", resp, er);
        chk("ones_cnt", ones, exp_ones(n));
        done_cyc = cyc;
        $display("xfer pat=%02h mode=%0d resp=%02h ones=%0d", pat, mode, resp, ones);
        if (chain) begin
            start   = 1'b1;
            data_in = next_pat;
        end else begin
            @(negedge clk);
            chk("done_once", done, 0);
            chk("busy_idle", busy, 0);
            chk("resp_hold", resp, er);
            chk("ones_hold", ones, exp_ones(n));
        end
    endtask

    initial begin
        int d1, d2, dd;
        logic [W-1:0] p;
        int m;
        reset = 1'b0; start = 1'b0; data_in = '0; y_drv = 1'b0; loop_en = 1'b0;
        start2 = 1'b0; data2 = '0;
        #12;
        chk("rst_x", x, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_resp", resp, 0);
        chk("rst_ones", ones, 0);
        @(negedge clk);
        reset = 1'b1;

        xfer(8'hA5, 0, 0, 0, 0, '0, dd);
        xfer(8'h00, 1, 0, 0, 0, '0, dd);
        xfer(8'hC3, 0, 0, 1, 0, '0, dd);
        xfer(8'hF0, 0, 0, 0, 1, 8'h0F, d1);
        xfer(8'h0F, 0, 1, 0, 0, '0, d2);
        chk("b2b_gap", d2 - d1, W + 1);

        // asynchronous reset in the middle of a transfer
        @(negedge clk);
        start = 1'b1; data_in = 8'h5A; loop_en = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_x", x, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_resp", resp, 0);
        chk("mid_rst_ones", ones, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
        end
        reset = 1'b1;
        xfer(8'h81, 0, 0, 0, 0, '0, dd);

        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            p = W'($urandom);
            m = int'($urandom_range(0, 2));
            if (m == 2) m = 3;
            xfer(p, m, 0, 0, 0, '0, dd);
        end

        @(negedge clk);
        start2 = 1'b1; data2 = 2'b10;
        @(posedge clk);
        #1 start2 = 1'b0;
        @(negedge clk);
        chk("w2_x0", x2, 1);
        chk("w2_busy", busy2, 1);
        @(negedge clk);
        chk("w2_x1", x2, 0);
        chk("w2_done_low", done2, 0);
        @(negedge clk);
        chk("w2_done", done2, 1);
        chk("w2_resp", resp2, 2'b01);
        chk("w2_ones", ones2, exp_ones(1));
        $display("w2 xfer pat=2 resp=%0h ones=%0d", resp2, ones2);
        @(negedge clk);
        chk("w2_done_once", done2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
